// File: rtl/fetch_unit_pkg.sv
// Shared fetch front-end definitions: queue entry layout and the boot PC.
package fetch_unit_pkg;

    localparam int unsigned FETCH_XLEN = 32;

    // First PC fetched after reset; the core uses the same constant.
    localparam logic [FETCH_XLEN-1:0] RESET_PC = 32'h0001_0000;

    // One fetch queue slot. The slot is allocated when its request is issued.
    // It becomes 'filled' once its instruction word has come back from imem.
    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [31:0]           instr;
        logic                  filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit.sv
// Decoupled instruction-fetch front end: pipelined imem requests, an in-order
// queue of {pc, instr} pairs, and a valid/ready hand-off to decode, with
// redirect flush and discard of stale in-flight responses.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN            = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC        = fetch_unit_pkg::RESET_PC,
    parameter int unsigned     DEPTH           = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    output logic                       imem_req_valid_o,
    input  logic                       imem_req_ready_i,
    output logic [XLEN-1:0]            imem_req_addr_o,
    input  logic                       imem_rsp_valid_i,
    input  logic [31:0]                imem_rsp_data_i,
    input  logic                       redirect_valid_i,
    input  logic [XLEN-1:0]            redirect_pc_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [XLEN-1:0]            out_pc_o,
    output logic [31:0]                out_instr_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [OUT_W:0]   MAX_OUT  = (OUT_W + 1)'(MAX_OUTSTANDING);

    fetch_entry_t     entries [DEPTH];
    logic [XLEN-1:0]  fetch_pc;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] fill;        // oldest allocated-but-unfilled slot
    logic [CNT_W-1:0] count;
    logic [OUT_W-1:0] inflight;    // requests whose response will fill a slot
    logic [OUT_W-1:0] discard;     // requests whose response must be dropped
    logic [OUT_W:0]   outstanding;
    logic             full;
    logic             req_fire;
    logic             pop;
    logic             rsp_fill;

    // Issue/pop qualification and head presentation.
    always_comb begin
        outstanding = {1'b0, inflight} + {1'b0, discard};
        full        = (count == FULL_CNT);
        // Gated by reset so the request port is quiet while reset is held.
        imem_req_valid_o = reset_ni && !full && (outstanding < MAX_OUT) && !redirect_valid_i;
        req_fire         = imem_req_valid_o && imem_req_ready_i;
        out_valid_o      = entries[head].filled && !redirect_valid_i;
        pop              = out_valid_o && out_ready_i;
        rsp_fill         = imem_rsp_valid_i && (discard == '0);
        imem_req_addr_o  = fetch_pc;
        out_pc_o         = entries[head].pc;
        out_instr_o      = entries[head].instr;
        count_o          = count;
    end

    // Queue, pointer, PC and outstanding-request bookkeeping; redirect wins.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            fill     <= '0;
            count    <= '0;
            inflight <= '0;
            discard  <= '0;
        end else if (redirect_valid_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i].filled <= 1'b0;
            end
            head     <= '0;
            tail     <= '0;
            fill     <= '0;
            count    <= '0;
            fetch_pc <= redirect_pc_i & ~XLEN'(3);
            // Everything still unanswered becomes stale, less any response
            // landing this very cycle.
            discard  <= OUT_W'(outstanding - (OUT_W + 1)'(imem_rsp_valid_i));
            inflight <= '0;
        end else begin
            if (req_fire) begin
                entries[tail].pc     <= fetch_pc;
                entries[tail].instr  <= '0;
                entries[tail].filled <= 1'b0;
                tail                 <= tail + PTR_W'(1);
                fetch_pc             <= fetch_pc + XLEN'(4);
            end
            if (imem_rsp_valid_i) begin
                if (discard != '0) begin
                    discard <= discard - OUT_W'(1);
                end else begin
                    entries[fill].instr  <= imem_rsp_data_i;
                    entries[fill].filled <= 1'b1;
                    fill                 <= fill + PTR_W'(1);
                end
            end
            if (pop) begin
                entries[head].filled <= 1'b0;
                head                 <= head + PTR_W'(1);
            end
            count    <= count + CNT_W'(req_fire) - CNT_W'(pop);
            inflight <= inflight + OUT_W'(req_fire) - OUT_W'(rsp_fill);
        end
    end

    // imem must never answer a request that was not issued.
    assert property (@(posedge clk_i) disable iff (!reset_ni)
        imem_rsp_valid_i |-> (outstanding != '0));

    // Allocation can never exceed the queue size.
    assert property (@(posedge clk_i) disable iff (!reset_ni)
        count <= FULL_CNT);

endmodule
